// File: rtl/dat_read_ctrl.sv
// Read-transfer sequencer for the SD DAT-line block receiver: gates one receiver
// start per block on buffer space, runs the data timeout, counts blocks, and reports status.
module dat_read_ctrl #(
  parameter int BlockCountWidth = 16,
  parameter int TimeoutWidth    = 27
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sd_clk_en_i,
  input  logic                       start_i,
  input  logic                       block_count_en_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic [TimeoutWidth-1:0]    timeout_cycles_i,
  input  logic                       stop_at_gap_i,
  input  logic                       buf_ready_i,
  output logic                       rx_start_o,
  output logic                       rx_timeout_o,
  input  logic                       rx_data_valid_i,
  input  logic                       rx_done_i,
  input  logic                       rx_crc_err_i,
  input  logic                       rx_end_bit_err_i,
  output logic                       busy_o,
  output logic [BlockCountWidth-1:0] blocks_left_o,
  output logic                       block_done_o,
  output logic                       xfer_complete_o,
  output logic                       gap_stop_o,
  output logic                       timeout_err_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_BUF, RECV, FINISH} state_e;

  state_e                     state;
  logic                       count_en;
  logic                       data_seen;
  logic [TimeoutWidth-1:0]    timeout_cnt;
  logic [BlockCountWidth-1:0] left_next;
  logic                       timeout_hit;

  // The receiver strobes must act in the same cycle as the tick that qualifies them,
  // so they are decoded from the registered state rather than registered themselves.
  assign rx_start_o  = (state == WAIT_BUF) && !stop_at_gap_i && buf_ready_i && sd_clk_en_i;
  assign timeout_hit = (state == RECV) && sd_clk_en_i && !data_seen && !rx_data_valid_i &&
                       (timeout_cycles_i != '0) &&
                       ((timeout_cnt + TimeoutWidth'(1)) == timeout_cycles_i);
  assign rx_timeout_o = timeout_hit && !rx_done_i;
  assign busy_o       = (state != IDLE);
  assign left_next    = (blocks_left_o == '0) ? '0 : blocks_left_o - BlockCountWidth'(1);

  // NOTE: all state below uses non-blocking assignments so every branch reads the
  // pre-edge values (e.g. left_next is computed from the old count, not the new one).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      count_en        <= 1'b0;
      data_seen       <= 1'b0;
      timeout_cnt     <= '0;
      blocks_left_o   <= '0;
      block_done_o    <= 1'b0;
      xfer_complete_o <= 1'b0;
      gap_stop_o      <= 1'b0;
      timeout_err_o   <= 1'b0;
      crc_err_o       <= 1'b0;
      end_bit_err_o   <= 1'b0;
    end else begin
      block_done_o    <= 1'b0;
      xfer_complete_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            gap_stop_o    <= 1'b0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            count_en      <= block_count_en_i;
            blocks_left_o <= block_count_i;
            if (block_count_en_i && (block_count_i == '0)) state <= FINISH;
            else                                            state <= WAIT_BUF;
          end
        end
        WAIT_BUF: begin
          if (stop_at_gap_i) begin
            gap_stop_o <= 1'b1;
            state      <= FINISH;
          end else if (rx_start_o) begin
            timeout_cnt <= '0;
            data_seen   <= 1'b0;
            state       <= RECV;
          end
        end
        RECV: begin
          if (rx_done_i) begin
            crc_err_o     <= crc_err_o | rx_crc_err_i;
            end_bit_err_o <= end_bit_err_o | rx_end_bit_err_i;
            if (rx_crc_err_i || rx_end_bit_err_i) begin
              state <= FINISH;
            end else begin
              block_done_o <= 1'b1;
              if (count_en) blocks_left_o <= left_next;
              if (count_en && (left_next == '0)) begin
                state <= FINISH;
              end else if (stop_at_gap_i) begin
                gap_stop_o <= 1'b1;
                state      <= FINISH;
              end else begin
                state <= WAIT_BUF;
              end
            end
          end else if (timeout_hit) begin
            timeout_err_o <= 1'b1;
            state         <= FINISH;
          end else if (rx_data_valid_i) begin
            data_seen <= 1'b1;
          end else if (sd_clk_en_i && !data_seen) begin
            timeout_cnt <= timeout_cnt + TimeoutWidth'(1);
          end
        end
        FINISH: begin
          xfer_complete_o <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
